// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, shared-ALU and response signals of the ALU share arbiter
interface alu_share_arbiter_if;
  // requester 0: pipeline EX stage
  logic        flush;
  logic        valid0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [3:0]  op0;
  logic        ready0;
  // requester 1: multi-cycle unit
  logic        valid1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic [3:0]  op1;
  logic        ready1;
  // shared ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_sel;
  logic [31:0] alu_result;
  // responses
  logic        resp_valid0;
  logic        resp_valid1;
  logic [31:0] resp_data;
  logic        busy;

  // requesters and the ALU itself sit on the master side
  modport master (
    output flush, valid0, a0, b0, op0, valid1, a1, b1, op1, alu_result,
    input  ready0, ready1, alu_a, alu_b, alu_op, alu_sel,
    input  resp_valid0, resp_valid1, resp_data, busy
  );

  // the arbiter sits on the slave side
  modport slave (
    input  flush, valid0, a0, b0, op0, valid1, a1, b1, op1, alu_result,
    output ready0, ready1, alu_a, alu_b, alu_op, alu_sel,
    output resp_valid0, resp_valid1, resp_data, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter with starvation guard in front of a shared ALU
module alu_share_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       force1;
  logic       s1_valid;
  logic       s1_kill;

  // requester 0 normally wins; requester 1 is forced through once it has waited LIMIT cycles
  assign force1     = bus.valid1 && (starve_cnt == LIMIT);
  assign bus.ready0 = bus.valid0 && !bus.flush && !force1;
  assign bus.ready1 = bus.valid1 && (force1 || !bus.valid0 || bus.flush);

  // a flush cancels a requester-0 op sitting in stage 1 before it can strobe
  assign s1_kill  = bus.flush && !bus.alu_sel;
  assign bus.busy = s1_valid || bus.resp_valid0 || bus.resp_valid1;

  // count consecutive cycles requester 1 is left waiting, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (bus.ready1 || !bus.valid1) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // stage 1: capture the winning operands; hold them when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      bus.alu_a   <= 32'd0;
      bus.alu_b   <= 32'd0;
      bus.alu_op  <= 4'd0;
      bus.alu_sel <= 1'b0;
    end else begin
      s1_valid <= bus.ready0 || bus.ready1;
      if (bus.ready0) begin
        bus.alu_a   <= bus.a0;
        bus.alu_b   <= bus.b0;
        bus.alu_op  <= bus.op0;
        bus.alu_sel <= 1'b0;
      end else if (bus.ready1) begin
        bus.alu_a   <= bus.a1;
        bus.alu_b   <= bus.b1;
        bus.alu_op  <= bus.op1;
        bus.alu_sel <= 1'b1;
      end
    end
  end

  // stage 2: register the ALU result and raise a one-cycle strobe to its owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid0 <= 1'b0;
      bus.resp_valid1 <= 1'b0;
      bus.resp_data   <= 32'd0;
    end else begin
      bus.resp_valid0 <= s1_valid && !bus.alu_sel && !bus.flush;
      bus.resp_valid1 <= s1_valid && bus.alu_sel;
      if (s1_valid && !s1_kill) begin
        bus.resp_data <= bus.alu_result;
      end
    end
  end

endmodule
